// File: rtl/reset_gen_if.sv
// Signal bundle between the board reset generator and its environment.
// The master side drives the reset sources; the slave side (reset_gen) drives the reset outputs.
interface reset_gen_if;
   logic       btn_n;
   logic       sw_req;
   logic       pll_locked;
   logic       arst_n_o;
   logic       busy;
   logic [1:0] cause;

   modport master (
      output btn_n,
      output sw_req,
      output pll_locked,
      input  arst_n_o,
      input  busy,
      input  cause
   );

   modport slave (
      input  btn_n,
      input  sw_req,
      input  pll_locked,
      output arst_n_o,
      output busy,
      output cause
   );
endinterface

// File: rtl/reset_gen.sv
// Global active-low reset source: POR, debounced pushbutton, software request and PLL lock loss.
// Define RESET_GEN_LOCK_MON_EN to synchronize pll_locked and use lock loss as a reset trigger.
module reset_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ASSERT_CYCLES   = 8,
   parameter int HOLDOFF_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   reset_gen_if.slave bus
);
   localparam int SYNC_STAGES = 2;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int AW = (ASSERT_CYCLES > 1) ? $clog2(ASSERT_CYCLES) : 1;
   localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

   localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW-1:0] ASSERT_LOAD  = AW'(ASSERT_CYCLES - 1);
   localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(HOLDOFF_CYCLES);

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_BTN  = 2'b01;
   localparam logic [1:0] CAUSE_SW   = 2'b10;
   localparam logic [1:0] CAUSE_LOCK = 2'b11;

   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_WAIT   = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   // ---------------- button synchronizer and debouncer ----------------
   logic [SYNC_STAGES-1:0] btn_sync_q;
   logic                   btn_s;
   logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
   logic                   btn_dn_q, btn_dn_d;
   logic                   press_q, press_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_sync_q <= '1;
      end else begin
         btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], bus.btn_n};
      end
   end

   assign btn_s = btn_sync_q[SYNC_STAGES-1];

   // btn_dn_q holds the debounced active-low level; press fires on its falling toggle.
   always_comb begin
      deb_cnt_d = '0;
      btn_dn_d  = btn_dn_q;
      press_d   = 1'b0;
      if (btn_s != btn_dn_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            btn_dn_d = btn_s;
            press_d  = ~btn_s;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_cnt_q <= '0;
         btn_dn_q  <= 1'b1;
         press_q   <= 1'b0;
      end else begin
         deb_cnt_q <= deb_cnt_d;
         btn_dn_q  <= btn_dn_d;
         press_q   <= press_d;
      end
   end

   // ---------------- PLL lock monitor ----------------
   logic lock_s;
   logic lock_loss;

`ifdef RESET_GEN_LOCK_MON_EN
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   lock_dly_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_sync_q <= '0;
         lock_dly_q  <= 1'b0;
      end else begin
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
         lock_dly_q  <= lock_sync_q[SYNC_STAGES-1];
      end
   end

   assign lock_s    = lock_sync_q[SYNC_STAGES-1];
   assign lock_loss = lock_dly_q & ~lock_s;
`else
   logic unused_pll_locked;

   assign unused_pll_locked = bus.pll_locked;
   assign lock_s            = 1'b1;
   assign lock_loss         = 1'b0;
`endif

   // ---------------- reset sequencer ----------------
   state_t        state_q;
   logic [AW-1:0] assert_cnt_q;
   logic [HW-1:0] hold_cnt_q;
   logic [1:0]    cause_q;
   logic          arst_n_q;
   logic          busy_q;

   logic          sw_ok;
   logic          run_trig;
   logic [1:0]    run_cause;

   assign sw_ok    = bus.sw_req && (hold_cnt_q == '0);
   assign run_trig = lock_loss || press_q || sw_ok;

   always_comb begin
      run_cause = CAUSE_SW;
      if (lock_loss) begin
         run_cause = CAUSE_LOCK;
      end else if (press_q) begin
         run_cause = CAUSE_BTN;
      end
   end

   // arst_n_q and busy_q are loaded from the next state so they track RUN with no extra delay.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_ASSERT;
         assert_cnt_q <= ASSERT_LOAD;
         hold_cnt_q   <= HOLDOFF_LOAD;
         cause_q      <= CAUSE_POR;
         arst_n_q     <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (lock_loss || press_q) begin
                  assert_cnt_q <= ASSERT_LOAD;
                  cause_q      <= lock_loss ? CAUSE_LOCK : CAUSE_BTN;
               end else if (assert_cnt_q == '0) begin
                  state_q <= ST_WAIT;
               end else begin
                  assert_cnt_q <= assert_cnt_q - 1'b1;
               end
            end
            ST_WAIT: begin
               if (press_q) begin
                  state_q      <= ST_ASSERT;
                  assert_cnt_q <= ASSERT_LOAD;
                  cause_q      <= CAUSE_BTN;
               end else if (btn_dn_q && lock_s) begin
                  state_q    <= ST_RUN;
                  hold_cnt_q <= HOLDOFF_LOAD;
                  arst_n_q   <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            ST_RUN: begin
               if (hold_cnt_q != '0) begin
                  hold_cnt_q <= hold_cnt_q - 1'b1;
               end
               if (run_trig) begin
                  state_q      <= ST_ASSERT;
                  assert_cnt_q <= ASSERT_LOAD;
                  cause_q      <= run_cause;
                  arst_n_q     <= 1'b0;
                  busy_q       <= 1'b1;
               end
            end
            default: begin
               state_q      <= ST_ASSERT;
               assert_cnt_q <= ASSERT_LOAD;
               arst_n_q     <= 1'b0;
               busy_q       <= 1'b1;
            end
         endcase
      end
   end

   assign bus.arst_n_o = arst_n_q;
   assign bus.busy     = busy_q;
   assign bus.cause    = cause_q;

endmodule
